// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared constants and packet type for the common data bus.
//   CDB_NUM_FU / CDB_DATA_W / CDB_ROB_IDX_W : default bus geometry
//   FU_*                                    : functional-unit slot indices
//   cdb_pkt_t                               : {data, rob_idx} as carried on the CDB
package cdb_arbiter_pkg;

  localparam int unsigned CDB_NUM_FU    = 5;
  localparam int unsigned CDB_DATA_W    = 32;
  localparam int unsigned CDB_ROB_IDX_W = 3;

  localparam int unsigned FU_ALU = 0;
  localparam int unsigned FU_BR  = 1;
  localparam int unsigned FU_MUL = 2;
  localparam int unsigned FU_DIV = 3;
  localparam int unsigned FU_MEM = 4;

  typedef struct packed {
    logic [CDB_DATA_W-1:0]    data;
    logic [CDB_ROB_IDX_W-1:0] rob_idx;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_slot_fifo.sv
// cdb_slot_fifo: per-FU result buffer, DEPTH entries of pkt_t.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write data_i (caller guarantees !full_o)
//   pop_i         : drop head (caller guarantees !empty_o)
//   flush_i       : empty the buffer; overrides push/pop in the same cycle
//   full_o        : no free entry
//   empty_o       : no valid entry
//   head_o        : oldest entry
module cdb_slot_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         pkt_t = cdb_pkt_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  pkt_t data_i,
  output logic full_o,
  output logic empty_o,
  output pkt_t head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  pkt_t             mem_q [DEPTH];

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers FU results and broadcasts one per cycle on the CDB,
// granting buffered results round-robin.
//   clk_in, rst_in   : clock, asynchronous active-low reset
//   flush_in         : mispredict flush, empties all buffers, kills the grant
//   fu_valid_in      : per-FU result valid (held until fu_ready_out)
//   fu_data_in       : packed results, FU i at [i*DATA_W +: DATA_W]
//   fu_rob_idx_in    : packed ROB tags, same packing
//   fu_ready_out     : per-FU buffer not full
//   cdb_valid_out    : registered broadcast valid
//   cdb_data_out     : registered broadcast result (held when idle)
//   cdb_rob_idx_out  : registered broadcast ROB tag (held when idle)
//   cdb_src_out      : registered index of the granted FU (held when idle)
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_FU    = CDB_NUM_FU,
  parameter  int unsigned DATA_W    = CDB_DATA_W,
  parameter  int unsigned ROB_IDX_W = CDB_ROB_IDX_W,
  parameter  int unsigned DEPTH     = 2,
  localparam int unsigned SRC_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        flush_in,
  input  logic [NUM_FU-1:0]           fu_valid_in,
  input  logic [NUM_FU*DATA_W-1:0]    fu_data_in,
  input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx_in,
  output logic [NUM_FU-1:0]           fu_ready_out,
  output logic                        cdb_valid_out,
  output logic [DATA_W-1:0]           cdb_data_out,
  output logic [ROB_IDX_W-1:0]        cdb_rob_idx_out,
  output logic [SRC_W-1:0]            cdb_src_out
);

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [ROB_IDX_W-1:0] rob_idx;
  } pkt_t;

  logic [NUM_FU-1:0] full, empty, push, pop;
  pkt_t              head [NUM_FU];

  logic              grant_valid, do_pop;
  logic [SRC_W-1:0]  grant_idx;
  int unsigned       scan_idx;

  logic [SRC_W-1:0]  rr_last_q, rr_last_d;
  logic              cdb_valid_q, cdb_valid_d;
  pkt_t              cdb_pkt_q, cdb_pkt_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    pkt_t in_pkt;
    assign in_pkt.data    = fu_data_in[i*DATA_W +: DATA_W];
    assign in_pkt.rob_idx = fu_rob_idx_in[i*ROB_IDX_W +: ROB_IDX_W];
    assign push[i]        = fu_valid_in[i] && !full[i];
    assign pop[i]         = do_pop && (grant_idx == SRC_W'(i));

    cdb_slot_fifo #(
      .DEPTH (DEPTH),
      .pkt_t (pkt_t)
    ) u_fifo (
      .clk_i   (clk_in),
      .rst_ni  (rst_in),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .flush_i (flush_in),
      .data_i  (in_pkt),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .head_o  (head[i])
    );
  end

  // Scan starts just past the last winner and wraps, so the last winner
  // itself is checked last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int unsigned k = 1; k <= NUM_FU; k++) begin
      scan_idx = (int'(rr_last_q) + k) % NUM_FU;
      if (!grant_valid && !empty[SRC_W'(scan_idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(scan_idx);
      end
    end
  end

  assign do_pop = grant_valid && !flush_in;

  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_pkt_d   = cdb_pkt_q;
    cdb_src_d   = cdb_src_q;
    rr_last_d   = rr_last_q;
    if (do_pop) begin
      cdb_valid_d = 1'b1;
      cdb_pkt_d   = head[grant_idx];
      cdb_src_d   = grant_idx;
      rr_last_d   = grant_idx;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_last_q   <= SRC_W'(NUM_FU - 1);
      cdb_valid_q <= 1'b0;
      cdb_pkt_q   <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_last_q   <= rr_last_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_pkt_q   <= cdb_pkt_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign fu_ready_out    = ~full;
  assign cdb_valid_out   = cdb_valid_q;
  assign cdb_data_out    = cdb_pkt_q.data;
  assign cdb_rob_idx_out = cdb_pkt_q.rob_idx;
  assign cdb_src_out     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int NFU   = 5;
  localparam int DW    = 32;
  localparam int RW    = 3;
  localparam int DEPTH = 2;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              flush_in;
  logic [NFU-1:0]    fu_valid_in;
  logic [NFU*DW-1:0] fu_data_in;
  logic [NFU*RW-1:0] fu_rob_idx_in;
  logic [NFU-1:0]    fu_ready_out;
  logic              cdb_valid_out;
  logic [DW-1:0]     cdb_data_out;
  logic [RW-1:0]     cdb_rob_idx_out;
  logic [2:0]        cdb_src_out;

  cdb_arbiter #(
    .NUM_FU    (NFU),
    .DATA_W    (DW),
    .ROB_IDX_W (RW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .flush_in        (flush_in),
    .fu_valid_in     (fu_valid_in),
    .fu_data_in      (fu_data_in),
    .fu_rob_idx_in   (fu_rob_idx_in),
    .fu_ready_out    (fu_ready_out),
    .cdb_valid_out   (cdb_valid_out),
    .cdb_data_out    (cdb_data_out),
    .cdb_rob_idx_out (cdb_rob_idx_out),
    .cdb_src_out     (cdb_src_out)
  );

  always #5 clk_in = ~clk_in;

  int edge_cnt = 0;
  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected bus state after a given clock edge.
  typedef struct {
    int          edge_id;
    bit          valid;
    logic [31:0] data;
    logic [2:0]  rob;
    logic [2:0]  src;
  } exp_t;
  exp_t expq[$];

  typedef struct {
    logic [31:0] data;
    logic [2:0]  rob;
  } mpkt_t;

  // Reference model: one queue per FU, round-robin pointer, last bus value.
  mpkt_t       mq [NFU][$];
  int          rr;
  logic [31:0] last_data;
  logic [2:0]  last_rob;
  logic [2:0]  last_src;

  // FU-side stimulus: a pending result is held until the arbiter takes it.
  bit          pend_v [NFU];
  logic [31:0] pend_d [NFU];
  logic [2:0]  pend_r [NFU];
  bit          flush;

  task automatic model_reset();
    for (int i = 0; i < NFU; i++) begin
      mq[i].delete();
      pend_v[i] = 0;
    end
    rr        = NFU - 1;
    last_data = '0;
    last_rob  = '0;
    last_src  = '0;
    flush     = 0;
    expq.delete();
  endtask

  // Called at posedge+1: check ready, drive inputs, predict next edge, advance.
  task automatic cycle();
    bit    acc [NFU];
    bit    found;
    int    g, idx;
    mpkt_t p;
    exp_t  e;
    for (int i = 0; i < NFU; i++)
      chk($sformatf("ready[%0d]", i), 64'(fu_ready_out[i]), 64'(mq[i].size() < DEPTH));
    for (int i = 0; i < NFU; i++) begin
      fu_valid_in[i]           = pend_v[i];
      fu_data_in[i*DW +: DW]   = pend_v[i] ? pend_d[i] : $urandom;
      fu_rob_idx_in[i*RW +: RW] = pend_v[i] ? pend_r[i] : 3'($urandom);
      acc[i] = pend_v[i] && (mq[i].size() < DEPTH);
    end
    flush_in  = flush;
    e.edge_id = edge_cnt + 1;
    e.valid   = 0;
    if (flush) begin
      for (int i = 0; i < NFU; i++) mq[i].delete();
    end else begin
      found = 0;
      g     = 0;
      for (int k = 1; k <= NFU; k++) begin
        idx = (rr + k) % NFU;
        if (!found && mq[idx].size() > 0) begin
          found = 1;
          g     = idx;
        end
      end
      if (found) begin
        p         = mq[g].pop_front();
        last_data = p.data;
        last_rob  = p.rob;
        last_src  = 3'(g);
        rr        = g;
        e.valid   = 1;
      end
      for (int i = 0; i < NFU; i++)
        if (acc[i]) begin
          p.data = pend_d[i];
          p.rob  = pend_r[i];
          mq[i].push_back(p);
        end
    end
    for (int i = 0; i < NFU; i++) if (acc[i]) pend_v[i] = 0;
    e.data = last_data;
    e.rob  = last_rob;
    e.src  = last_src;
    expq.push_back(e);
    flush = 0;
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_pend(input int i, input logic [31:0] d, input logic [2:0] r);
    pend_v[i] = 1;
    pend_d[i] = d;
    pend_r[i] = r;
  endtask

  // Monitor: compares the bus against the prediction for the edge just taken.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (expq.size() > 0 && expq[0].edge_id == edge_cnt) begin
        e = expq.pop_front();
        chk("cdb_valid", 64'(cdb_valid_out), 64'(e.valid));
        chk("cdb_data",  64'(cdb_data_out),  64'(e.data));
        chk("cdb_rob",   64'(cdb_rob_idx_out), 64'(e.rob));
        chk("cdb_src",   64'(cdb_src_out),   64'(e.src));
      end
    end
  end

  initial begin
    int mul_sent;
    logic [31:0] mul_data [3];

    rst_in        = 1'b0;
    flush_in      = 1'b0;
    fu_valid_in   = '0;
    fu_data_in    = '0;
    fu_rob_idx_in = '0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset valid", 64'(cdb_valid_out), 64'd0);
    chk("reset data",  64'(cdb_data_out),  64'd0);
    chk("reset rob",   64'(cdb_rob_idx_out), 64'd0);
    chk("reset src",   64'(cdb_src_out),   64'd0);
    chk("reset ready", 64'(fu_ready_out),  64'h1f);
    rst_in = 1'b1;

    // Single ALU result.
    set_pend(0, 32'hDEAD_BEEF, 3'd3);
    repeat (5) cycle();

    // All five FUs at once, then a refill.
    for (int i = 0; i < NFU; i++) set_pend(i, $urandom, 3'(i));
    repeat (6) cycle();
    for (int i = 0; i < NFU; i++) set_pend(i, $urandom, 3'(i));
    repeat (6) cycle();

    // Reset while a broadcast is on the bus.
    for (int i = 0; i < NFU; i++) set_pend(i, $urandom, 3'(i));
    repeat (3) cycle();
    chk("pre-reset valid", 64'(cdb_valid_out), 64'd1);
    rst_in = 1'b0;
    expq.delete();
    #1;
    chk("mid-reset valid", 64'(cdb_valid_out), 64'd0);
    chk("mid-reset data",  64'(cdb_data_out),  64'd0);
    chk("mid-reset rob",   64'(cdb_rob_idx_out), 64'd0);
    chk("mid-reset src",   64'(cdb_src_out),   64'd0);
    chk("mid-reset ready", 64'(fu_ready_out),  64'h1f);
    model_reset();
    fu_valid_in = '0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;

    // MUL backpressure while ALU and BR keep requesting.
    for (int j = 0; j < 3; j++) mul_data[j] = 32'hC0DE_0000 + 32'(j);
    mul_sent = 0;
    for (int c = 0; c < 14; c++) begin
      if (!pend_v[0]) set_pend(0, $urandom, 3'($urandom));
      if (!pend_v[1]) set_pend(1, $urandom, 3'($urandom));
      if (!pend_v[2] && mul_sent < 3) begin
        set_pend(2, mul_data[mul_sent], 3'(mul_sent));
        mul_sent++;
      end
      cycle();
    end
    pend_v[0] = 0;
    pend_v[1] = 0;
    repeat (10) cycle();

    // Flush with four results buffered and a push in the flush cycle.
    for (int i = 0; i < 4; i++) set_pend(i, $urandom, 3'(i));
    cycle();
    set_pend(4, 32'h5555_AAAA, 3'd4);
    flush = 1;
    cycle();
    repeat (3) cycle();

    // Random soak.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NFU; i++)
        if (!pend_v[i] && $urandom_range(0, 1) == 1) set_pend(i, $urandom, 3'($urandom));
      flush = ($urandom_range(0, 499) == 0);
      cycle();
    end
    for (int i = 0; i < NFU; i++) pend_v[i] = 0;
    repeat (12) cycle();

    @(negedge clk_in);
    #1;
    chk("scoreboard drained", 64'(expq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
